// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: operand/request and HI/LO/status bundle between core and mdu_hilo.
interface mdu_hilo_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic             sgn;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             dz;
  modport master (output start, op, sgn, src_a, src_b, input hi, lo, busy, done, dz);
  modport slave  (input start, op, sgn, src_a, src_b, output hi, lo, busy, done, dz);
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative shift-add multiply / restoring divide with HI/LO registers.
// Signed arithmetic (sgn=1) is built only when MDU_SIGNED_EN is defined.
module mdu_hilo #(parameter int WIDTH = 32) (
  input logic       clk,
  input logic       rst,
  mdu_hilo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t               state_q;
  logic [WIDTH:0]       r_q, r_d, sum, shl, diff;
  logic [WIDTH-1:0]     s_q, s_d, m_q, hi_q, lo_q, a_mag, b_mag, q_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod, prod_fix;
  logic [CW-1:0]        cnt_q;
  logic                 div_q, neg_q, rneg_q, bz_q, busy_q, done_q, dz_q, sa, sb;
`ifdef MDU_SIGNED_EN
  assign sa = bus.sgn & bus.src_a[WIDTH-1];
  assign sb = bus.sgn & bus.src_b[WIDTH-1];
`else
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif
  assign a_mag = sa ? -bus.src_a : bus.src_a;
  assign b_mag = sb ? -bus.src_b : bus.src_b;
  // r_q/s_q form {upper, lower} of the product, or {remainder, dividend/quotient}
  always_comb begin
    sum      = {1'b0, r_q[WIDTH-1:0]} + (s_q[0] ? {1'b0, m_q} : '0);
    shl      = {r_q[WIDTH-1:0], s_q[WIDTH-1]};
    diff     = shl - {1'b0, m_q};
    r_d      = div_q ? (diff[WIDTH] ? shl : diff) : {1'b0, sum[WIDTH:1]};
    s_d      = div_q ? {s_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], s_q[WIDTH-1:1]};
    prod     = {r_d[WIDTH-1:0], s_d};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = bz_q ? '1 : (neg_q ? -s_d : s_d);
    rem_fix  = rneg_q ? -r_d[WIDTH-1:0] : r_d[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      s_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == RUN) begin
        r_q   <= r_d;
        s_q   <= s_d;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_q      <= DONE;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          dz_q         <= div_q & bz_q;
          {hi_q, lo_q} <= div_q ? {rem_fix, q_fix} : prod_fix;
        end
      end else begin
        state_q <= IDLE;
        if (bus.start) begin
          if (bus.op[1]) begin
            if (bus.op[0]) lo_q <= bus.src_a;
            else hi_q <= bus.src_a;
          end else begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(WIDTH);
            div_q   <= bus.op[0];
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            bz_q    <= (bus.src_b == '0);
            m_q     <= b_mag;
            s_q     <= a_mag;
            r_q     <= '0;
          end
        end
      end
    end
  end
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed checks of mdu_hilo (WIDTH=32) with hand-computed results.
module tb_mdu_hilo;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  mdu_hilo_if #(.WIDTH(32)) bus ();
  mdu_hilo #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // drives a request across one accepting edge, returns at the following negedge
  task automatic issue(input logic [1:0] op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.sgn   = sgn;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int exp_cycles);
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_cycles));
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
  endtask
  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.sgn = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_flags", {61'd0, bus.busy, bus.done, bus.dz}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    issue(2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("mult_max", 32);
    chk("mult_max_res", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    chk("mult_max_dz", 64'(bus.dz), 64'd0);
    @(negedge clk);
    chk("done_pulse", 64'(bus.done), 64'd0);
    issue(2'b01, 1'b0, 32'd100, 32'd7);
    wait_done("div", 32);
    chk("div_res", {bus.hi, bus.lo}, {32'd2, 32'd14});
    chk("div_dz", 64'(bus.dz), 64'd0);
    @(negedge clk);
    issue(2'b01, 1'b0, 32'h1234, 32'd0);
    wait_done("divz", 32);
    chk("divz_res", {bus.hi, bus.lo}, {32'h1234, 32'hFFFFFFFF});
    chk("divz_dz", 64'(bus.dz), 64'd1);
    @(negedge clk);
    issue(2'b01, 1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("abort_flags", {61'd0, bus.busy, bus.done, bus.dz}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(2'b00, 1'b0, 32'd2, 32'd3);
    wait_done("mult_after_rst", 32);
    chk("mult_after_rst_res", {bus.hi, bus.lo}, {32'd0, 32'd6});
    @(negedge clk);
    issue(2'b10, 1'b0, 32'hDEADBEEF, 32'd0);
    chk("mthi_res", {bus.hi, bus.lo}, {32'hDEADBEEF, 32'd6});
    chk("mthi_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    chk("mthi_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    issue(2'b00, 1'b0, 32'd6, 32'd7);
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.src_a = 32'h55555555;
    bus.src_b = 32'h99;
    @(negedge clk);
    bus.op = 2'b00;
    @(negedge clk);
    bus.op = 2'b10;
    @(negedge clk);
    chk("run_hold", {bus.hi, bus.lo}, {32'hDEADBEEF, 32'd6});
    bus.op = 2'b01;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("run_ign", 28);
    chk("run_ign_res", {bus.hi, bus.lo}, {32'd0, 32'd42});
    @(negedge clk);
    issue(2'b01, 1'b0, 32'd50, 32'd8);
    wait_done("b2b_div", 32);
    chk("b2b_div_res", {bus.hi, bus.lo}, {32'd2, 32'd6});
    issue(2'b00, 1'b0, 32'd3, 32'd5);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done("b2b_mult", 32);
    chk("b2b_mult_res", {bus.hi, bus.lo}, {32'd0, 32'd15});
    @(negedge clk);
`ifdef MDU_SIGNED_EN
    issue(2'b00, 1'b1, 32'hFFFFFFFD, 32'd5);
    wait_done("smult", 32);
    chk("smult_res", {bus.hi, bus.lo}, {32'hFFFFFFFF, 32'hFFFFFFF1});
    @(negedge clk);
    issue(2'b01, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done("sdiv", 32);
    chk("sdiv_res", {bus.hi, bus.lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    @(negedge clk);
    issue(2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done("sdiv_ovf", 32);
    chk("sdiv_ovf_res", {bus.hi, bus.lo}, {32'd0, 32'h80000000});
    chk("sdiv_ovf_dz", 64'(bus.dz), 64'd0);
    @(negedge clk);
    issue(2'b01, 1'b1, 32'hFFFFFFF9, 32'd0);
    wait_done("sdivz", 32);
    chk("sdivz_res", {bus.hi, bus.lo}, {32'hFFFFFFF9, 32'hFFFFFFFF});
    chk("sdivz_dz", 64'(bus.dz), 64'd1);
`else
    issue(2'b00, 1'b1, 32'hFFFFFFFD, 32'd5);
    wait_done("umult_sgn", 32);
    chk("umult_sgn_res", {bus.hi, bus.lo}, {32'h00000004, 32'hFFFFFFF1});
    @(negedge clk);
    issue(2'b01, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done("udiv_sgn", 32);
    chk("udiv_sgn_res", {bus.hi, bus.lo}, {32'd1, 32'h7FFFFFFC});
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
